// File: rtl/l1_miss_refill.sv
// ============================================================================
// Module      : l1_miss_refill
// Description : Single-outstanding L1 miss refill engine. Accepts a miss,
//               issues a line-aligned read to L2, assembles the returned
//               beats into one cache line and hands a fill transaction back
//               to L1. Protocol faults and error beats poison the fill.
//               Optional L2 response watchdog: define L1_REFILL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_miss_refill #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 256,
    parameter int BUS_W       = 64,
    parameter int OFFS_W      = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              l2_req_valid,
    output logic [ADDR_W-1:0] l2_req_addr,
    input  logic              l2_req_ready,
    input  logic              l2_rsp_valid,
    input  logic [BUS_W-1:0]  l2_rsp_data,
    input  logic              l2_rsp_last,
    input  logic              l2_rsp_err,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              fill_err,
    input  logic              fill_ready,
    output logic              busy
);

    localparam int c_BEATS = LINE_W / BUS_W;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_BEATS - 1);

    localparam int c_WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [c_WDOG_W-1:0] c_WDOG_LIMIT = c_WDOG_W'(TIMEOUT_CYC - 1);

    localparam logic [ADDR_W-1:0] c_OFFS_MASK = ADDR_W'((64'd1 << OFFS_W) - 64'd1);

`ifdef L1_REFILL_TIMEOUT_EN
    localparam logic c_WDOG_EN = 1'b1;
`else
    // Watchdog compare is tied off; the counter has no fanout and is pruned.
    localparam logic c_WDOG_EN = 1'b0;
`endif

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_REQ     = 2'd1;
    localparam logic [1:0] c_S_COLLECT = 2'd2;
    localparam logic [1:0] c_S_FILL    = 2'd3;

    logic [1:0]          r_state;
    logic                r_miss_ready;
    logic [ADDR_W-1:0]   r_line_addr;
    logic [LINE_W-1:0]   r_line;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;
    logic [c_WDOG_W-1:0] r_wdog;

    logic [ADDR_W-1:0]   w_line_addr;
    logic                w_at_last;
    logic                w_timeout;

    assign w_line_addr = miss_addr & ~c_OFFS_MASK;
    assign w_at_last   = (r_cnt == c_LAST_CNT);
    assign w_timeout   = c_WDOG_EN && (r_wdog == c_WDOG_LIMIT);

    // Refill FSM with line assembly, error accumulation and watchdog.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_S_IDLE;
            r_miss_ready <= 1'b1;
            r_line_addr  <= '0;
            r_line       <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_wdog       <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (miss_valid) begin
                        r_line_addr  <= w_line_addr;
                        r_line       <= '0;
                        r_cnt        <= '0;
                        r_err        <= 1'b0;
                        r_miss_ready <= 1'b0;
                        r_state      <= c_S_REQ;
                    end
                end
                c_S_REQ: begin
                    // L2 never answers before accepting, so beats here are ignored.
                    if (l2_req_ready) begin
                        r_wdog  <= '0;
                        r_state <= c_S_COLLECT;
                    end
                end
                c_S_COLLECT: begin
                    if (l2_rsp_valid) begin
                        r_line[r_cnt*BUS_W +: BUS_W] <= l2_rsp_data;
                        r_wdog <= '0;
                        if (!w_at_last) begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                        if (l2_rsp_last || w_at_last) begin
                            // Last marker must coincide with the final beat.
                            r_err   <= r_err | l2_rsp_err | (l2_rsp_last != w_at_last);
                            r_state <= c_S_FILL;
                        end else begin
                            r_err <= r_err | l2_rsp_err;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_S_FILL;
                    end else begin
                        r_wdog <= r_wdog + c_WDOG_W'(1);
                    end
                end
                c_S_FILL: begin
                    // A miss presented alongside fill acceptance waits one cycle.
                    if (fill_ready) begin
                        r_miss_ready <= 1'b1;
                        r_state      <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign miss_ready   = r_miss_ready;
    assign l2_req_valid = (r_state == c_S_REQ);
    assign l2_req_addr  = r_line_addr;
    assign fill_valid   = (r_state == c_S_FILL);
    assign fill_addr    = r_line_addr;
    assign fill_data    = r_line;
    assign fill_err     = (r_state == c_S_FILL) && r_err;
    assign busy         = (r_state != c_S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_l1_miss_refill.sv
// ============================================================================
// Module      : tb_l1_miss_refill
// Description : Directed self-checking bench for l1_miss_refill. Inputs are
//               driven and outputs sampled 1ns after each rising edge.
//               Watchdog scenario selected by L1_REFILL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_miss_refill;

    logic         clk;
    logic         rst;
    logic         miss_valid;
    logic [15:0]  miss_addr;
    logic         miss_ready;
    logic         l2_req_valid;
    logic [15:0]  l2_req_addr;
    logic         l2_req_ready;
    logic         l2_rsp_valid;
    logic [63:0]  l2_rsp_data;
    logic         l2_rsp_last;
    logic         l2_rsp_err;
    logic         fill_valid;
    logic [15:0]  fill_addr;
    logic [255:0] fill_data;
    logic         fill_err;
    logic         fill_ready;
    logic         busy;

    int checks;
    int errors;

    l1_miss_refill #(
        .ADDR_W      (16),
        .LINE_W      (256),
        .BUS_W       (64),
        .OFFS_W      (5),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .l2_req_valid (l2_req_valid),
        .l2_req_addr  (l2_req_addr),
        .l2_req_ready (l2_req_ready),
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_data  (l2_rsp_data),
        .l2_rsp_last  (l2_rsp_last),
        .l2_rsp_err   (l2_rsp_err),
        .fill_valid   (fill_valid),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .fill_err     (fill_err),
        .fill_ready   (fill_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a miss and let L2 accept the request immediately.
    task automatic start_miss(input logic [15:0] addr);
        miss_valid   = 1'b1;
        miss_addr    = addr;
        l2_req_ready = 1'b1;
        tick();
        miss_valid = 1'b0;
        tick();
        l2_req_ready = 1'b0;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic last, input logic err);
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = d;
        l2_rsp_last  = last;
        l2_rsp_err   = err;
        tick();
        l2_rsp_valid = 1'b0;
        l2_rsp_last  = 1'b0;
        l2_rsp_err   = 1'b0;
    endtask

    task automatic accept_fill();
        fill_ready = 1'b1;
        tick();
        fill_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL reset_miss_ready got %b exp 1", miss_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", l2_req_valid); end
        checks++; if (fill_valid !== 1'b0 || fill_err !== 1'b0) begin errors++; $display("FAIL reset_fill got v=%b e=%b exp 0 0", fill_valid, fill_err); end
        checks++; if (fill_data !== 256'h0 || fill_addr !== 16'h0) begin errors++; $display("FAIL reset_payload got addr=%h data=%h exp 0", fill_addr, fill_data); end
    endtask

    task automatic test_basic();
        miss_valid   = 1'b1;
        miss_addr    = 16'h1234;
        l2_req_ready = 1'b1;
        tick();
        miss_valid = 1'b0;
        checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 16'h1220) begin errors++; $display("FAIL basic_req got v=%b a=%h exp 1 1220", l2_req_valid, l2_req_addr); end
        checks++; if (miss_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_busy got mr=%b busy=%b exp 0 1", miss_ready, busy); end
        tick();
        l2_req_ready = 1'b0;
        checks++; if (l2_req_valid !== 1'b0 || fill_valid !== 1'b0) begin errors++; $display("FAIL basic_collect got req=%b fill=%b exp 0 0", l2_req_valid, fill_valid); end
        drive_beat(64'hA0, 1'b0, 1'b0);
        drive_beat(64'hA1, 1'b0, 1'b0);
        drive_beat(64'hA2, 1'b0, 1'b0);
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL basic_early_fill got %b exp 0", fill_valid); end
        drive_beat(64'hA3, 1'b1, 1'b0);
        checks++; if (fill_valid !== 1'b1 || fill_addr !== 16'h1220 || fill_err !== 1'b0) begin errors++; $display("FAIL basic_fill got v=%b a=%h e=%b exp 1 1220 0", fill_valid, fill_addr, fill_err); end
        checks++; if (fill_data !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin errors++; $display("FAIL basic_data got %h", fill_data); end
        accept_fill();
        checks++; if (fill_valid !== 1'b0 || miss_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got fv=%b mr=%b busy=%b exp 0 1 0", fill_valid, miss_ready, busy); end
    endtask

    task automatic test_backpressure();
        miss_valid = 1'b1;
        miss_addr  = 16'hBEEF;
        tick();
        miss_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 16'hBEE0 || miss_ready !== 1'b0) begin errors++; $display("FAIL bp_req_hold cyc %0d got v=%b a=%h mr=%b exp 1 bee0 0", i, l2_req_valid, l2_req_addr, miss_ready); end
            tick();
        end
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0;
        drive_beat(64'hB0, 1'b0, 1'b0);
        drive_beat(64'hB1, 1'b0, 1'b0);
        drive_beat(64'hB2, 1'b0, 1'b0);
        drive_beat(64'hB3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (fill_valid !== 1'b1 || fill_addr !== 16'hBEE0 || miss_ready !== 1'b0 || fill_data !== {64'hB3, 64'hB2, 64'hB1, 64'hB0}) begin errors++; $display("FAIL bp_fill_hold cyc %0d got v=%b a=%h mr=%b d=%h", i, fill_valid, fill_addr, miss_ready, fill_data); end
            tick();
        end
        // A miss offered in the fill-acceptance cycle must not be taken.
        miss_valid = 1'b1;
        miss_addr  = 16'h4444;
        fill_ready = 1'b1;
        tick();
        fill_ready = 1'b0;
        miss_valid = 1'b0;
        checks++; if (busy !== 1'b0 || miss_ready !== 1'b1 || l2_req_valid !== 1'b0) begin errors++; $display("FAIL bp_return_idle got busy=%b mr=%b req=%b exp 0 1 0", busy, miss_ready, l2_req_valid); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_same_cycle_miss got busy=%b exp 0", busy); end
    endtask

    task automatic test_error_beat();
        start_miss(16'h0040);
        drive_beat(64'hC0, 1'b0, 1'b0);
        drive_beat(64'hC1, 1'b0, 1'b1);
        drive_beat(64'hC2, 1'b0, 1'b0);
        drive_beat(64'hC3, 1'b1, 1'b0);
        checks++; if (fill_valid !== 1'b1 || fill_err !== 1'b1 || fill_addr !== 16'h0040) begin errors++; $display("FAIL errbeat_fill got v=%b e=%b a=%h exp 1 1 0040", fill_valid, fill_err, fill_addr); end
        checks++; if (fill_data !== {64'hC3, 64'hC2, 64'hC1, 64'hC0}) begin errors++; $display("FAIL errbeat_data got %h", fill_data); end
        accept_fill();
    endtask

    task automatic test_early_last();
        start_miss(16'h2345);
        drive_beat(64'hD0, 1'b0, 1'b0);
        drive_beat(64'hD1, 1'b1, 1'b0);
        checks++; if (fill_valid !== 1'b1 || fill_err !== 1'b1 || fill_addr !== 16'h2340) begin errors++; $display("FAIL early_last_fill got v=%b e=%b a=%h exp 1 1 2340", fill_valid, fill_err, fill_addr); end
        checks++; if (fill_data !== {128'h0, 64'hD1, 64'hD0}) begin errors++; $display("FAIL early_last_data got %h", fill_data); end
        accept_fill();
    endtask

    task automatic test_missing_last();
        start_miss(16'h7FFF);
        drive_beat(64'hE0, 1'b0, 1'b0);
        drive_beat(64'hE1, 1'b0, 1'b0);
        drive_beat(64'hE2, 1'b0, 1'b0);
        drive_beat(64'hE3, 1'b0, 1'b0);
        checks++; if (fill_valid !== 1'b1 || fill_err !== 1'b1 || fill_addr !== 16'h7FE0) begin errors++; $display("FAIL missing_last_fill got v=%b e=%b a=%h exp 1 1 7fe0", fill_valid, fill_err, fill_addr); end
        drive_beat(64'hE4, 1'b1, 1'b0);
        checks++; if (fill_valid !== 1'b1 || fill_data !== {64'hE3, 64'hE2, 64'hE1, 64'hE0}) begin errors++; $display("FAIL missing_last_drop got v=%b d=%h", fill_valid, fill_data); end
        accept_fill();
    endtask

    task automatic test_reset_mid_collect();
        start_miss(16'h5678);
        drive_beat(64'hF0, 1'b0, 1'b0);
        drive_beat(64'hF1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (busy !== 1'b0 || miss_ready !== 1'b1 || fill_valid !== 1'b0 || l2_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_state got busy=%b mr=%b fv=%b req=%b exp 0 1 0 0", busy, miss_ready, fill_valid, l2_req_valid); end
        checks++; if (fill_data !== 256'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", fill_data); end
        drive_beat(64'hF2, 1'b1, 1'b0);
        drive_beat(64'hF3, 1'b1, 1'b1);
        checks++; if (busy !== 1'b0 || fill_valid !== 1'b0 || miss_ready !== 1'b1 || fill_data !== 256'h0) begin errors++; $display("FAIL midrst_stray got busy=%b fv=%b mr=%b d=%h", busy, fill_valid, miss_ready, fill_data); end
    endtask

`ifdef L1_REFILL_TIMEOUT_EN
    task automatic test_timeout();
        start_miss(16'h0100);
        drive_beat(64'h11, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", fill_valid); end
        tick();
        checks++; if (fill_valid !== 1'b1 || fill_err !== 1'b1 || fill_data !== {192'h0, 64'h11}) begin errors++; $display("FAIL timeout_fill got v=%b e=%b d=%h", fill_valid, fill_err, fill_data); end
        accept_fill();
    endtask
`else
    task automatic test_timeout();
        start_miss(16'h0100);
        drive_beat(64'h11, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        checks++; if (fill_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL no_watchdog got fv=%b busy=%b exp 0 1", fill_valid, busy); end
        drive_beat(64'h22, 1'b0, 1'b0);
        drive_beat(64'h33, 1'b0, 1'b0);
        drive_beat(64'h44, 1'b1, 1'b0);
        checks++; if (fill_valid !== 1'b1 || fill_err !== 1'b0 || fill_data !== {64'h44, 64'h33, 64'h22, 64'h11}) begin errors++; $display("FAIL no_watchdog_fill got v=%b e=%b d=%h", fill_valid, fill_err, fill_data); end
        accept_fill();
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        miss_valid   = 1'b0;
        miss_addr    = 16'h0;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = 64'h0;
        l2_rsp_last  = 1'b0;
        l2_rsp_err   = 1'b0;
        fill_ready   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_error_beat();
        test_early_last();
        test_missing_last();
        test_reset_mid_collect();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
